// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port (instruction read-only, data read/write)
// round-robin arbiter in front of a single combinational-read memory.
// Each transaction takes IDLE -> ACCESS -> DONE. The memory is driven
// only during ACCESS, and the winner sees a one-cycle ack in DONE.
//
// Handshake: a requester raises req together with stable address,
// write flag and write data. It holds all of them until it sees its
// ack for one cycle, then either drops req or keeps it high to issue
// a new transaction. Inputs are sampled only in IDLE. The arbiter
// never asserts both acks in the same cycle.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction port (read-only)
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_read_data,
  // data port
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_write_data,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_read_data,
  // memory side
  output logic                  memory_read,
  output logic                  memory_write,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0] memory_write_data,
  input  logic [DATA_WIDTH-1:0] memory_read_data,
  // debug: current FSM state (0=IDLE, 1=ACCESS, 2=DONE)
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  state_e                state_q;
  port_e                 winner_q;
  port_e                 last_grant_q;
  port_e                 grant_d;
  logic                  we_q;
  logic                  any_req;
  logic                  grant_we_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  mem_rd_q;
  logic                  mem_wr_q;
  logic                  i_ack_q;
  logic                  d_ack_q;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  assign any_req = i_req | d_req;

  // Arbitration: a lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    grant_d = PORT_I;
    if (i_req && d_req) begin
      grant_d = (last_grant_q == PORT_D) ? PORT_I : PORT_D;
    end else if (d_req) begin
      grant_d = PORT_D;
    end
    // Only the data port can write; an instruction grant is always a read.
    grant_we_d = (grant_d == PORT_D) ? d_write : 1'b0;
  end

  // Main FSM with registered memory strobes, acks and read-data holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      winner_q     <= PORT_I;
      last_grant_q <= PORT_D;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          if (any_req) begin
            winner_q <= grant_d;
            we_q     <= grant_we_d;
            if (grant_d == PORT_D) begin
              addr_q  <= d_address;
              wdata_q <= d_write_data;
            end else begin
              // The instruction port has no store data; keep the last value.
              addr_q  <= i_address;
            end
            // Strobes are registered so they are high exactly during ACCESS.
            mem_rd_q <= ~grant_we_d;
            mem_wr_q <= grant_we_d;
            state_q  <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          if (!we_q) begin
            if (winner_q == PORT_D) begin
              d_rdata_q <= memory_read_data;
            end else begin
              i_rdata_q <= memory_read_data;
            end
          end
          if (winner_q == PORT_D) begin
            d_ack_q <= 1'b1;
          end else begin
            i_ack_q <= 1'b1;
          end
          state_q <= S_DONE;
        end

        S_DONE: begin
          i_ack_q      <= 1'b0;
          d_ack_q      <= 1'b0;
          last_grant_q <= winner_q;
          state_q      <= S_IDLE;
        end

        default: begin
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          i_ack_q  <= 1'b0;
          d_ack_q  <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign i_ack             = i_ack_q;
  assign d_ack             = d_ack_q;
  assign i_read_data       = i_rdata_q;
  assign d_read_data       = d_rdata_q;
  assign memory_read       = mem_rd_q;
  assign memory_write      = mem_wr_q;
  assign memory_address    = addr_q;
  assign memory_write_data = wdata_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed steps followed by randomized rounds, checked
// against a transaction-level model (grant order, ack cycle offsets, memory image).
module tb_memory_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  // ---------------- DUT signals ----------------
  logic          i_req, d_req, d_write;
  logic [AW-1:0] i_address, d_address;
  logic [DW-1:0] d_write_data;
  logic          i_ack, d_ack;
  logic [DW-1:0] i_read_data, d_read_data;
  logic          memory_read, memory_write;
  logic [AW-1:0] memory_address;
  logic [DW-1:0] memory_write_data, memory_read_data;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_address(i_address), .i_ack(i_ack), .i_read_data(i_read_data),
    .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_write_data(d_write_data),
    .d_ack(d_ack), .d_read_data(d_read_data),
    .memory_read(memory_read), .memory_write(memory_write),
    .memory_address(memory_address), .memory_write_data(memory_write_data),
    .memory_read_data(memory_read_data), .dbg_state(dbg_state)
  );

  // ---------------- memory model (64 words) ----------------
  logic [31:0] ref_mem [64];
  logic [31:0] mem [64];
  logic        load_mem = 1'b0;

  always @(posedge clk) begin
    if (load_mem) mem <= ref_mem;
    else if (memory_write) mem[memory_address[7:2]] <= memory_write_data;
  end
  assign memory_read_data = mem[memory_address[7:2]];

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    i_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_write_data = '0;
  endtask

  // safety net: the flow below is bounded, this only guards against a stuck kernel
  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random flow ----------------
  initial begin
    int ack_t_i, ack_t_d, wr_cnt, exp_wr;
    logic ri, rd, dw, last_d, first_d;
    logic [31:0] ia, da, dd, exp_i_rd, exp_d_rd;
    logic [31:0] wr_old;

    drive_idle();
    #1 rst_n = 1'b0;
    #1;
    // async reset values, before any clock edge
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_i_ack", 32'(i_ack), 32'd0);
    check("rst_d_ack", 32'(d_ack), 32'd0);
    check("rst_mem_rd", 32'(memory_read), 32'd0);
    check("rst_mem_wr", 32'(memory_write), 32'd0);
    check("rst_mem_addr", memory_address, 32'd0);
    check("rst_mem_wdata", memory_write_data, 32'd0);
    check("rst_i_rdata", i_read_data, 32'd0);
    check("rst_d_rdata", d_read_data, 32'd0);

    foreach (ref_mem[i]) ref_mem[i] = $urandom;
    ref_mem[4] = 32'hDEADBEEF;        // 0x10
    load_mem = 1'b1;
    step();
    load_mem = 1'b0;
    step();
    rst_n = 1'b1;
    check("post_rst_idle", 32'(dbg_state), 32'd0);

    // single data read of 0x10
    d_req = 1'b1; d_write = 1'b0; d_address = 32'h10;
    step();
    check("rd_t1_mem_rd", 32'(memory_read), 32'd1);
    check("rd_t1_mem_wr", 32'(memory_write), 32'd0);
    check("rd_t1_addr", memory_address, 32'h10);
    check("rd_t1_d_ack", 32'(d_ack), 32'd0);
    step();
    check("rd_t2_d_ack", 32'(d_ack), 32'd1);
    check("rd_t2_i_ack", 32'(i_ack), 32'd0);
    check("rd_t2_data", d_read_data, 32'hDEADBEEF);
    check("rd_t2_mem_rd", 32'(memory_read), 32'd0);
    d_req = 1'b0;
    step();
    check("rd_t3_d_ack", 32'(d_ack), 32'd0);

    // data write 0x20 then instruction read of 0x20
    d_req = 1'b1; d_write = 1'b1; d_address = 32'h20; d_write_data = 32'hCAFEF00D;
    wr_cnt = 0;
    for (int t = 1; t <= 3; t++) begin
      step();
      wr_cnt += int'(memory_write);
      if (t == 2) begin
        check("wr_d_ack", 32'(d_ack), 32'd1);
        d_req = 1'b0; d_write = 1'b0;
      end
    end
    ref_mem[8] = 32'hCAFEF00D;
    check("wr_pulse_count", 32'(wr_cnt), 32'd1);
    check("wr_keeps_d_rdata", d_read_data, 32'hDEADBEEF);
    check("wr_wdata_held", memory_write_data, 32'hCAFEF00D);
    i_req = 1'b1; i_address = 32'h20;
    step();
    check("ird_mem_rd", 32'(memory_read), 32'd1);
    step();
    check("ird_i_ack", 32'(i_ack), 32'd1);
    check("ird_data", i_read_data, 32'hCAFEF00D);
    i_req = 1'b0;
    step();

    // tie right after reset: instruction first, data three cycles later
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    i_req = 1'b1; i_address = 32'h10;
    d_req = 1'b1; d_write = 1'b0; d_address = 32'h20;
    for (int t = 1; t <= 6; t++) begin
      step();
      check($sformatf("tie_i_ack_t%0d", t), 32'(i_ack), 32'(t == 2));
      check($sformatf("tie_d_ack_t%0d", t), 32'(d_ack), 32'(t == 5));
      if (i_ack) begin
        check("tie_i_data", i_read_data, 32'hDEADBEEF);
        i_req = 1'b0;
      end
      if (d_ack) begin
        check("tie_d_data", d_read_data, 32'hCAFEF00D);
        d_req = 1'b0;
      end
    end

    // sustained contention: last grant was data, so I, D, I, D every 3 cycles
    i_req = 1'b1; i_address = 32'h20;
    d_req = 1'b1; d_write = 1'b0; d_address = 32'h10;
    for (int t = 1; t <= 12; t++) begin
      step();
      check($sformatf("sus_i_ack_t%0d", t), 32'(i_ack), 32'((t % 3 == 2) && ((t / 3) % 2 == 0)));
      check($sformatf("sus_d_ack_t%0d", t), 32'(d_ack), 32'((t % 3 == 2) && ((t / 3) % 2 == 1)));
      if (i_ack) check("sus_i_data", i_read_data, 32'hCAFEF00D);
      if (d_ack) check("sus_d_data", d_read_data, 32'hDEADBEEF);
      if (t == 12) begin
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    step();
    check("sus_end_idle", 32'(dbg_state), 32'd0);

    // reset during the ACCESS cycle of a write to 0x30
    wr_old = ref_mem[12];
    d_req = 1'b1; d_write = 1'b1; d_address = 32'h30; d_write_data = 32'h12345678;
    step();
    check("rstw_mem_wr_before", 32'(memory_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_mem_wr_dropped", 32'(memory_write), 32'd0);
    check("rstw_state_idle", 32'(dbg_state), 32'd0);
    check("rstw_addr_cleared", memory_address, 32'd0);
    step();
    check("rstw_mem_kept", mem[12], wr_old);
    check("rstw_no_d_ack", 32'(d_ack), 32'd0);
    check("rstw_no_i_ack", 32'(i_ack), 32'd0);
    drive_idle();
    step();
    rst_n = 1'b1;

    // idle: no requests for 10 cycles
    for (int t = 1; t <= 10; t++) begin
      step();
      check($sformatf("idle_mem_rd_t%0d", t), 32'(memory_read), 32'd0);
      check($sformatf("idle_mem_wr_t%0d", t), 32'(memory_write), 32'd0);
      check($sformatf("idle_i_ack_t%0d", t), 32'(i_ack), 32'd0);
      check($sformatf("idle_d_ack_t%0d", t), 32'(d_ack), 32'd0);
    end

    // randomized rounds against the transaction-level model
    last_d = 1'b1;          // last grant resets to the data port
    exp_i_rd = 32'd0;
    exp_d_rd = 32'd0;
    for (int r = 0; r < 40; r++) begin
      do begin
        ri = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
      end while (!ri && !rd);
      ia = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      da = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      dw = 1'($urandom_range(0, 1));
      dd = $urandom;

      // grant order: lone requester, or on a tie the port not granted last
      if (ri && rd) first_d = ~last_d;
      else first_d = rd;
      ack_t_i = 0; ack_t_d = 0; exp_wr = 0;
      if (ri && rd) begin
        ack_t_i = first_d ? 5 : 2;
        ack_t_d = first_d ? 2 : 5;
        last_d = ~first_d;
      end else if (ri) begin
        ack_t_i = 2;
        last_d = 1'b0;
      end else begin
        ack_t_d = 2;
        last_d = 1'b1;
      end
      // apply the memory effects in grant order
      for (int k = 0; k < 2; k++) begin
        logic is_d;
        is_d = (k == 0) ? first_d : ~first_d;
        if (k == 1 && !(ri && rd)) break;
        if (!is_d) exp_i_rd = ref_mem[ia[7:2]];
        else if (dw) begin
          ref_mem[da[7:2]] = dd;
          exp_wr++;
        end else exp_d_rd = ref_mem[da[7:2]];
      end

      i_req = ri; i_address = ia;
      d_req = rd; d_address = da; d_write = dw; d_write_data = dd;
      wr_cnt = 0;
      for (int t = 1; t <= 6; t++) begin
        step();
        wr_cnt += int'(memory_write);
        check($sformatf("r%0d_i_ack_t%0d", r, t), 32'(i_ack), 32'(t == ack_t_i));
        check($sformatf("r%0d_d_ack_t%0d", r, t), 32'(d_ack), 32'(t == ack_t_d));
        if (i_ack) begin
          check($sformatf("r%0d_i_data", r), i_read_data, exp_i_rd);
          i_req = 1'b0;
        end
        if (d_ack) begin
          check($sformatf("r%0d_d_data", r), d_read_data, exp_d_rd);
          d_req = 1'b0;
        end
      end
      drive_idle();
      check($sformatf("r%0d_wr_count", r), 32'(wr_cnt), 32'(exp_wr));
      check($sformatf("r%0d_i_hold", r), i_read_data, exp_i_rd);
      check($sformatf("r%0d_d_hold", r), d_read_data, exp_d_rd);
    end

    // final memory image must match the model
    foreach (ref_mem[i]) begin
      check($sformatf("mem_img_%0d", i), mem[i], ref_mem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of every address bus.
REQ-002 Parameter DATA_WIDTH, default 32, width of every data bus.
REQ-003 One clock and one reset: reset is asynchronous and active-low; ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 i_req  input  1  instruction-port request; read-only port.
REQ-007 i_address  input  ADDR_WIDTH  instruction-port byte address.
REQ-008 i_ack  output  1  instruction-port completion pulse.
REQ-009 i_read_data  output  DATA_WIDTH  instruction-port read data; valid when i_ack=1.
REQ-010 d_req  input  1  data-port request.
REQ-011 d_write  input  1  data-port direction; 1=write, 0=read.
REQ-012 d_address  input  ADDR_WIDTH  data-port byte address.
REQ-013 d_write_data  input  DATA_WIDTH  data-port store data.
REQ-014 d_ack  output  1  data-port completion pulse.
REQ-015 d_read_data  output  DATA_WIDTH  data-port read data; valid when d_ack=1.
REQ-016 memory_read  output  1  to memory: read enable; memory read_data is combinational.
REQ-017 memory_write  output  1  to memory: write enable; memory writes on the next rising clk.
REQ-018 memory_address  output  ADDR_WIDTH  to memory: byte address.
REQ-019 memory_write_data  output  DATA_WIDTH  to memory: store data.
REQ-020 memory_read_data  input  DATA_WIDTH  from memory: read data.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS, DONE.
REQ-022 IDLE: no request -> stay; any req -> latch the winner's address, write flag (0 for instruction) and write data; record the winner; go to ACCESS.
REQ-023 Arbitration: a single requester wins; if both request, the port NOT granted last wins (round-robin); the last_grant register resets to DATA, so the first tie goes to instruction.
REQ-024 ACCESS, one cycle: drive memory_address/memory_write_data from the latched registers; memory_read=~we; memory_write=we; on the closing edge, capture memory_read_data into the winner's read_data register (read only); go to DONE.
REQ-025 Outside ACCESS, memory_read=0 and memory_write=0; memory_address and memory_write_data hold their last latched values.
REQ-026 DONE, one cycle: assert the winner's ack for exactly one cycle; update last_grant; go to IDLE.
REQ-027 Latency: req sampled in IDLE at cycle 0 -> ack high in cycle 2; a back-to-back issue slot is at most one per 3 cycles.
REQ-028 Requesters SHALL hold req, address, write and write_data stable until ack; these inputs are sampled only in IDLE.
REQ-029 A req still high in the IDLE cycle after ack is treated as a new transaction.
REQ-030 The loser of a tie keeps req high; it SHALL be granted in the next IDLE (no starvation).
REQ-031 i_read_data and d_read_data SHALL hold their value until the next read completes on the same port.
REQ-032 On a data write, d_read_data is not updated.
REQ-033 i_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-034 While rst_n=0, immediately (not waiting for clk): state=IDLE, last_grant=DATA, i_ack=d_ack=0, memory_read=memory_write=0, memory_address=0, memory_write_data=0, i_read_data=d_read_data=0.
REQ-035 Reset asserted mid-transaction aborts it: no ack is issued, and a write in ACCESS is suppressed if rst_n falls before the closing edge.
REQ-036 After deassertion, the first IDLE cycle samples requests normally.

Verification
REQ-037 Single read: memory word 0x10=0xDEADBEEF, d_req=1 with d_write=0 and d_address=0x10 -> memory_read=1 in cycle 1, d_ack=1 in cycle 2, d_read_data=0xDEADBEEF.
REQ-038 Write then read: write 0xCAFEF00D to d_address 0x20, then an instruction read of i_address 0x20 -> i_read_data=0xCAFEF00D; memory_write is high for exactly one cycle.
REQ-039 Tie after reset: i_req and d_req rise together -> i_ack in cycle 2, d_ack in cycle 5, never in the same cycle.
REQ-040 Sustained contention: both reqs held high for 12 cycles -> acks alternate I, D, I, D with 3-cycle spacing.
REQ-041 Reset in ACCESS during a write to 0x30 -> memory_write drops with rst_n, 0x30 keeps its old value, and no ack is issued.
REQ-042 Idle: no reqs for 10 cycles -> memory_read=memory_write=0 and no acks throughout.
